// File: rtl/bcd_freq_pkg.sv
// Shared types and constants for the BCD frequency counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_freq_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } fsm_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counting chain: wraps 9->0 and signals carry to the next decade.
// Latency: q updates on the clk edge after en/clr; carry is combinational from en and q.
// Backpressure: none; clr (synchronous load) has priority over en.
module bcd_digit
    import bcd_freq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  bcd_digit_t load_val,
    input  logic       en,
    output bcd_digit_t q,
    output logic       carry
);

    assign carry = en && (q == BCD_MAX);

    // Digit register: load on clr, otherwise count decimally when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= load_val;
        end else if (en) begin
            q <= (q == BCD_MAX) ? bcd_digit_t'(0) : q + bcd_digit_t'(1);
        end
    end

endmodule

// File: rtl/bcd_freq_counter.sv
// Gated BCD frequency counter: counts sig_in rising edges over GATE_CYCLES clk, latches result.
// Latency: sig_in rise to count 2-3 clk; valid pulses the cycle after the window's LATCH cycle.
// Backpressure: none; start is ignored while busy. Macro BCD_FREQ_SATURATE_EN: saturate at all-9s.
module bcd_freq_counter
    import bcd_freq_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int GATE_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sig_in,
    input  logic                  start,
    input  logic                  continuous,
    output logic [4*N_DIGITS-1:0] count_bcd,
    output logic                  overflow,
    output logic                  valid,
    output logic                  busy
);

    localparam int TIMER_W = $clog2(GATE_CYCLES);
    // GATE covers timer values 0..GATE_CYCLES-2; the single LATCH cycle that
    // follows is the last cycle of the window, giving exactly GATE_CYCLES cycles.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 2);

    fsm_state_t                  state, state_nxt;
    logic [TIMER_W-1:0]          timer;
    logic                        timer_clr, timer_inc;
    logic                        digit_clr, count_en, latch_en;
    logic                        sync_q1, sync_q2, sync_q3;
    logic                        inc, inc_gate, all_nines, ovf_hit, sticky_ovf;
    bcd_digit_t                  load0;
    bcd_digit_t [N_DIGITS-1:0]   digit_q;
    logic [N_DIGITS:0]           chain;

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= sig_in;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign inc = sync_q2 & ~sync_q3;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and per-state control strobes.
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        digit_clr = 1'b0;
        count_en  = 1'b0;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                digit_clr = 1'b1;
                timer_clr = 1'b1;
                if (continuous || start) begin
                    state_nxt = GATE;
                end
            end
            GATE: begin
                count_en  = 1'b1;
                timer_inc = 1'b1;
                if (timer == TIMER_LAST) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                digit_clr = 1'b1;
                latch_en  = 1'b1;
                timer_clr = 1'b1;
                state_nxt = continuous ? GATE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate timer: cleared outside GATE, counts while the window is open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer_inc) begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Detect the all-9s state so an increment there is recognised as overflow.
    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_q[i] != BCD_MAX) begin
                all_nines = 1'b0;
            end
        end
    end

    assign inc_gate = count_en & inc;
    // An edge landing in the LATCH cycle seeds the next window's digit 0; in
    // IDLE the load is zero so any such edge is dropped.
    assign load0    = bcd_digit_t'(latch_en & inc);

`ifdef BCD_FREQ_SATURATE_EN
    // Block the increment once all digits read 9 so the chain sticks there.
    assign chain[0] = inc_gate & ~all_nines;
`else
    assign chain[0] = inc_gate;
`endif

    // In wrap mode the top carry is the overflow event; in saturate mode the
    // increment never reaches the chain, so the all-9s term catches it.
    assign ovf_hit = chain[N_DIGITS] | (inc_gate & all_nines);

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .clr      (digit_clr),
            .load_val ((i == 0) ? load0 : bcd_digit_t'(0)),
            .en       (chain[i]),
            .q        (digit_q[i]),
            .carry    (chain[i+1])
        );
    end

    // Sticky overflow: set by any overflow in the window, cleared at window end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_ovf <= 1'b0;
        end else if (digit_clr) begin
            sticky_ovf <= 1'b0;
        end else if (ovf_hit) begin
            sticky_ovf <= 1'b1;
        end
    end

    // Display buffer: capture digits and overflow in LATCH, pulse valid alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= latch_en;
            if (latch_en) begin
                count_bcd <= digit_q;
                overflow  <= sticky_ovf;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
